// File: rtl/out_drain_ctrl.sv
// Result-buffer collector and requantizing drain for the array output path.
// Collects accumulating partial sums into a buffer, then streams q(buf[k]) out as a valid/ready sequence.
module out_drain_ctrl #(
   parameter int ACC_W = 24,
   parameter int AW    = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    enable,
   input  logic [1:0]              mode,
   input  logic                    cfg_load,
   input  logic [AW:0]             cfg_len,
   input  logic [4:0]              cfg_shift,
   input  logic                    cfg_relu,
   input  logic                    res_valid,
   input  logic [AW-1:0]           res_addr,
   input  logic                    res_first,
   input  logic signed [ACC_W-1:0] res_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [7:0]       out_data,
   output logic                    out_last,
   output logic                    done,
   output logic                    res_drop
);

   localparam int DEPTH = 1 << AW;
   localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);
   localparam logic [1:0] MODE_COLLECT = 2'b01;
   localparam logic [1:0] MODE_DRAIN   = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

   state_t                  state_reg, state_next;
   logic [AW:0]             len_reg;
   logic [4:0]              shift_reg;
   logic                    relu_reg;
   logic [AW:0]             idx_reg, idx_next;
   logic                    out_valid_reg, out_valid_next;
   logic signed [7:0]       out_data_reg, out_data_next;
   logic                    out_last_reg, out_last_next;
   logic                    done_reg, done_next;
   logic                    res_drop_reg;

   logic signed [ACC_W-1:0] res_buf [DEPTH];
   logic                    wr_en;
   logic signed [ACC_W-1:0] wr_data;
   logic [AW:0]             idx_plus;
   logic [AW:0]             len_m1;
   logic [AW-1:0]           rd_addr;
   logic signed [7:0]       rd_q;

   function automatic logic signed [7:0] quant(input logic signed [ACC_W-1:0] x,
                                               input logic [4:0] sh,
                                               input logic relu);
      logic signed [ACC_W-1:0] y;
      y = x >>> sh;
      if (relu && y[ACC_W-1]) y = '0;
      if (y > Q_MAX)      y = Q_MAX;
      else if (y < Q_MIN) y = Q_MIN;
      return $signed(y[7:0]);
   endfunction

   // Read-modify-write completes within one cycle, so back-to-back beats to one address never stall.
   assign wr_en   = (state_reg == S_COLLECT) && enable && res_valid;
   assign wr_data = (res_first ? '0 : res_buf[res_addr]) + res_data;

   always_ff @(posedge clk) begin
      if (wr_en) res_buf[res_addr] <= wr_data;
   end

   assign idx_plus = idx_reg + (AW+1)'(1);
   assign len_m1   = len_reg - (AW+1)'(1);
   // In IDLE the read port is parked on entry 0 so the first beat is ready on the DRAIN edge.
   assign rd_addr  = (state_reg == S_DRAIN) ? idx_plus[AW-1:0] : '0;
   assign rd_q     = quant(res_buf[rd_addr], shift_reg, relu_reg);

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      out_last_next  = out_last_reg;
      done_next      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (enable) begin
               if (mode == MODE_COLLECT) begin
                  state_next = S_COLLECT;
               end else if (mode == MODE_DRAIN) begin
                  if (len_reg == '0) begin
                     state_next = S_DONE;
                     done_next  = 1'b1;
                  end else begin
                     state_next     = S_DRAIN;
                     idx_next       = '0;
                     out_valid_next = 1'b1;
                     out_data_next  = rd_q;
                     out_last_next  = (len_reg == (AW+1)'(1));
                  end
               end
            end
         end
         S_COLLECT: begin
            if (enable && (mode != MODE_COLLECT)) state_next = S_IDLE;
         end
         S_DRAIN: begin
            if (out_valid_reg && out_ready) begin
               if (out_last_reg) begin
                  state_next     = S_DONE;
                  out_valid_next = 1'b0;
                  out_last_next  = 1'b0;
                  done_next      = 1'b1;
               end else begin
                  idx_next      = idx_plus;
                  out_data_next = rd_q;
                  out_last_next = (idx_plus == len_m1);
               end
            end
         end
         S_DONE: begin
            if (enable && (mode != MODE_DRAIN)) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg     <= S_IDLE;
         len_reg       <= '0;
         shift_reg     <= '0;
         relu_reg      <= 1'b0;
         idx_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         done_reg      <= 1'b0;
         res_drop_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_last_reg  <= out_last_next;
         done_reg      <= done_next;
         if (state_reg == S_IDLE && enable && cfg_load) begin
            len_reg   <= cfg_len;
            shift_reg <= cfg_shift;
            relu_reg  <= cfg_relu;
         end
         if (res_valid && state_reg != S_COLLECT) res_drop_reg <= 1'b1;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;
   assign done      = done_reg;
   assign res_drop  = res_drop_reg;

endmodule

// File: tb/tb_out_drain_ctrl.sv
// Scoreboard bench for out_drain_ctrl: drivers push expected drain beats, a negedge monitor pops and compares.
// The reference keeps the buffer as plain integers and quantizes with floor division and clamping.
module tb_out_drain_ctrl;
   localparam int ACC_W = 24;
   localparam int AW    = 8;

   logic                    clk = 1'b0;
   logic                    rstn, enable, cfg_load, cfg_relu;
   logic [1:0]              mode;
   logic [AW:0]             cfg_len;
   logic [4:0]              cfg_shift;
   logic                    res_valid, res_first;
   logic [AW-1:0]           res_addr;
   logic signed [ACC_W-1:0] res_data;
   logic                    out_valid, out_ready, out_last, done, res_drop;
   logic signed [7:0]       out_data;

   out_drain_ctrl #(.ACC_W(ACC_W), .AW(AW)) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .mode(mode), .cfg_load(cfg_load),
      .cfg_len(cfg_len), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .res_valid(res_valid), .res_addr(res_addr), .res_first(res_first), .res_data(res_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .done(done), .res_drop(res_drop)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {int data; bit last;} exp_t;
   exp_t   exp_q[$];
   exp_t   mon_e;
   longint m_buf [1 << AW];
   int     m_len = 0, m_shift = 0;
   bit     m_relu = 0;
   int     done_cnt = 0;
   int     exp_done_cyc = -1;
   int     ready_pat = 0;
   int     rp_cnt = 0;
   bit     pv = 0, pr = 0, pl = 0;
   int     pd = 0;

   task automatic check(string name, longint act, longint expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic longint wrap_acc(longint v);
      longint m;
      m = longint'(1) << ACC_W;
      v = v % m;
      if (v < 0) v += m;
      if (v >= m / 2) v -= m;
      return v;
   endfunction

   function automatic int qref(longint x, int sh, bit relu);
      longint d, y;
      d = longint'(1) << sh;
      if (x >= 0) y = x / d;
      else        y = -((-x + d - 1) / d);
      if (relu && y < 0) y = 0;
      if (y > 127)  y = 127;
      if (y < -128) y = -128;
      return int'(y);
   endfunction

   function automatic int rnd();
      return int'($urandom_range(0, 400000)) - 200000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(int d, bit last);
      exp_t e;
      e.data = d;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic do_config(int len, int sh, bit relu);
      enable = 1'b1; mode = 2'b00; cfg_load = 1'b1;
      cfg_len = (AW+1)'(len); cfg_shift = 5'(sh); cfg_relu = relu;
      tick();
      cfg_load = 1'b0;
      m_len = len; m_shift = sh; m_relu = relu;
   endtask

   task automatic collect_begin();
      enable = 1'b1; mode = 2'b01;
      tick();
   endtask

   task automatic collect_end();
      res_valid = 1'b0; enable = 1'b1; mode = 2'b00;
      tick();
   endtask

   task automatic beat(int a, int d, bit first, bit en);
      enable = en; res_valid = 1'b1; res_addr = AW'(a); res_data = ACC_W'(d); res_first = first;
      tick();
      if (en) m_buf[a] = first ? wrap_acc(d) : wrap_acc(m_buf[a] + d);
   endtask

   task automatic drain(int pat, bit use_model);
      int base, i;
      if (use_model)
         for (int k = 0; k < m_len; k++) push_exp(qref(m_buf[k], m_shift, m_relu), k == m_len - 1);
      base = done_cnt;
      ready_pat = pat;
      rp_cnt = 0;
      enable = 1'b1;
      mode = 2'b10;
      if (m_len == 0) exp_done_cyc = cyc + 1;
      tick();
      if (m_len != 0) check("valid_rise", out_valid, 1);
      else            check("no_valid_len0", out_valid, 0);
      mode = 2'b00;
      i = 0;
      while (!(done_cnt != base && exp_q.size() == 0) && i < 4000) begin
         tick();
         i++;
      end
      if (i >= 4000) begin
         tests++; fails++;
         $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      end
      repeat (3) tick();
      check("done_pulses", done_cnt - base, 1);
      check("queue_drained", exp_q.size(), 0);
      ready_pat = 0;
   endtask

   task automatic rand_phase(int len, int pat);
      int a;
      do_config(len, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      collect_begin();
      for (int k = 0; k < len; k++) beat(k, rnd(), 1'b1, 1'b1);
      for (int j = 0; j < len; j++) begin
         a = int'($urandom_range(0, len - 1));
         repeat (3) beat(a, rnd(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end
      collect_end();
      drain(pat, 1'b1);
   endtask

   // Downstream ready: 0 always ready, 1 pattern 1,0,0,..., 2 random.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_pat)
            0: out_ready = 1'b1;
            1: begin out_ready = (rp_cnt % 3 == 0); rp_cnt++; end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               check("stall_valid", out_valid, 1);
               check("stall_data", out_data, pd);
               check("stall_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_beat: got data %0d, expected no beat", out_data);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("beat_data", out_data, mon_e.data);
                  check("beat_last", out_last, mon_e.last);
                  if (mon_e.last) exp_done_cyc = cyc + 1;
               end
            end
            if (done) begin
               done_cnt++;
               if (exp_done_cyc >= 0) check("done_timing", cyc, exp_done_cyc);
               exp_done_cyc = -1;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      rstn = 1'b0; enable = 1'b0; mode = 2'b00; cfg_load = 1'b0; cfg_len = '0;
      cfg_shift = '0; cfg_relu = 1'b0; res_valid = 1'b0; res_addr = '0;
      res_first = 1'b0; res_data = '0;
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_done", done, 0);
      check("rst_res_drop", res_drop, 0);
      rstn = 1'b1;
      tick();

      // Known-value collect and quantize; a cfg_load inside COLLECT must be ignored.
      do_config(4, 3, 1'b0);
      collect_begin();
      beat(0, 1000, 1'b1, 1'b1);
      beat(1, 1000, 1'b1, 1'b1);
      cfg_load = 1'b1; cfg_len = (AW+1)'(1); cfg_shift = 5'd0;
      beat(1, 200, 1'b0, 1'b1);
      cfg_load = 1'b0;
      beat(1, -100, 1'b0, 1'b1);
      beat(2, -50, 1'b1, 1'b1);
      beat(3, -2000, 1'b1, 1'b1);
      collect_end();
      push_exp(125, 0); push_exp(127, 0); push_exp(-7, 0); push_exp(-128, 1);
      drain(0, 1'b0);
      do_config(4, 3, 1'b1);
      push_exp(125, 0); push_exp(127, 0); push_exp(0, 0); push_exp(0, 1);
      drain(1, 1'b0);
      do_config(4, 4, 1'b0);
      push_exp(62, 0); push_exp(68, 0); push_exp(-4, 0); push_exp(-125, 1);
      drain(2, 1'b0);

      do_config(0, 0, 1'b0);
      drain(0, 1'b0);

      for (int r = 0; r < 6; r++) rand_phase(int'($urandom_range(1, 20)), r % 3);
      rand_phase(256, 2);
      check("no_drop_yet", res_drop, 0);

      // A beat in IDLE is dropped and flagged; buf[0] keeps its collected value.
      do_config(1, 0, 1'b0);
      collect_begin();
      beat(0, -20, 1'b1, 1'b1);
      collect_end();
      res_valid = 1'b1; res_addr = '0; res_data = ACC_W'(100); res_first = 1'b1;
      tick();
      res_valid = 1'b0;
      check("res_drop_set", res_drop, 1);
      drain(0, 1'b1);

      // Reset two beats into an 8-beat drain.
      do_config(8, 0, 1'b0);
      for (int k = 0; k < 8; k++) push_exp(qref(m_buf[k], 0, 1'b0), k == 7);
      ready_pat = 0;
      mode = 2'b10;
      tick();
      mode = 2'b00;
      i = 0;
      while (exp_q.size() > 6 && i < 100) begin
         tick();
         i++;
      end
      rstn = 1'b0;
      tick();
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_out_last", out_last, 0);
      check("midrst_done", done, 0);
      check("midrst_res_drop", res_drop, 0);
      rstn = 1'b1;
      exp_q.delete();
      exp_done_cyc = -1;
      m_len = 0; m_shift = 0; m_relu = 1'b0;
      tick();
      // Cleared length makes an unconfigured drain complete with no beats.
      drain(0, 1'b0);

      rand_phase(12, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
